// File: rtl/imem_boot_loader.sv
// imem_boot_loader: framed byte-stream loader for the instruction memory.
// Frame: LEN_HI, LEN_LO (word count N, big-endian), then N*4 payload bytes MSB first.
// Holds the core in reset until the full image has been written.
// Optional feature macro: IMEM_BOOT_CHECKSUM_EN adds a trailing XOR checksum byte.
module imem_boot_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned LEN_W = 16;
  localparam int unsigned SH_W  = 24;

`ifdef IMEM_BOOT_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHK, S_DONE, S_ERR
  } state_t;
  localparam state_t S_FIN = S_CHK;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_DONE, S_ERR
  } state_t;
  localparam state_t S_FIN = S_DONE;
`endif

  state_t            state, state_next;
  logic [7:0]        len_hi;
  logic [LEN_W-1:0]  len;
  logic [1:0]        byte_cnt;
  logic [SH_W-1:0]   shreg;
  logic [ADDR_W-1:0] idx;
`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [7:0]        chk;
`endif

  logic             accept;
  logic             load_start;
  logic             word_done;
  logic             last_word;
  logic [LEN_W-1:0] frame_len;
  logic             busy_next;
  logic             done_next;
  logic             error_next;

  assign accept     = in_valid & in_ready;
  assign frame_len  = {len_hi, in_data};
  assign last_word  = (LEN_W'(idx) == (len - LEN_W'(1)));
  assign word_done  = accept && (state == S_DATA) && (byte_cnt == 2'd3);
  assign load_start = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  // Next-state and next-output decode
  always_comb begin
    state_next = state;
    busy_next  = 1'b0;
    done_next  = 1'b0;
    error_next = 1'b0;
    case (state)
      S_IDLE:   if (start) state_next = S_LEN_HI;
      S_LEN_HI: if (accept) state_next = S_LEN_LO;
      S_LEN_LO: begin
        if (accept) begin
          if (frame_len == '0)                 state_next = S_FIN;
          else if (32'(frame_len) > MAX_WORDS) state_next = S_ERR;
          else                                 state_next = S_DATA;
        end
      end
      S_DATA:   if (word_done && last_word) state_next = S_FIN;
`ifdef IMEM_BOOT_CHECKSUM_EN
      S_CHK:    if (accept) state_next = (in_data == chk) ? S_DONE : S_ERR;
`endif
      S_DONE, S_ERR: if (start) state_next = S_LEN_HI;
      default:  state_next = S_IDLE;
    endcase
    case (state_next)
      S_LEN_HI, S_LEN_LO, S_DATA: busy_next = 1'b1;
`ifdef IMEM_BOOT_CHECKSUM_EN
      S_CHK:    busy_next  = 1'b1;
`endif
      S_DONE:   done_next  = 1'b1;
      S_ERR:    error_next = 1'b1;
      default:  busy_next  = 1'b0;
    endcase
  end

  // Registered status outputs, aligned with the state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      cpu_rst_n <= 1'b0;
    end else begin
      in_ready  <= busy_next;
      busy      <= busy_next;
      done      <= done_next;
      error     <= error_next;
      cpu_rst_n <= done_next;
    end
  end

  // Length capture, word assembly and memory write strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_hi    <= '0;
      len       <= '0;
      byte_cnt  <= '0;
      shreg     <= '0;
      idx       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
      chk       <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      if (load_start) begin
        idx      <= '0;
        byte_cnt <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
        chk      <= '0;
`endif
      end
      if (accept && (state == S_LEN_HI)) len_hi <= in_data;
      if (accept && (state == S_LEN_LO)) begin
        len      <= frame_len;
        byte_cnt <= '0;
      end
      if (accept && (state == S_DATA)) begin
        byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_BOOT_CHECKSUM_EN
        chk      <= chk ^ in_data;
`endif
        if (byte_cnt == 2'd3) begin
          mem_we    <= 1'b1;
          mem_addr  <= idx;
          mem_wdata <= {shreg, in_data};
          idx       <= idx + ADDR_W'(1);
        end else begin
          shreg <= {shreg[SH_W-9:0], in_data};
        end
      end
    end
  end

endmodule
